dot_seq: RTL and testbench
==========================

DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 Parameter DW, default 8: operand width.
REQ-002 Parameter ACCW, default 32: accumulator/result width.
REQ-003 Parameter LENW, default 8: length field width; job length = cfg_len+1 (1..256).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_valid  in  1  job request.
REQ-007 cfg_ready  out  1  job accepted when cfg_valid&cfg_ready.
REQ-008 cfg_len  in  LENW  pair count minus one.
REQ-009 cfg_asigned / cfg_wsigned  in  1 each  operand A / W treated as two's complement when 1, unsigned when 0.
REQ-010 in_valid  in  1  operand pair valid.
REQ-011 in_ready  out  1  pair accepted when in_valid&in_ready.
REQ-012 in_a / in_w  in  DW each  operands.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  result consumed when out_valid&out_ready.
REQ-015 out_acc  out  ACCW  signed dot-product result.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE, with cfg_ready=(IDLE), in_ready=(RUN), out_valid=(DONE).
REQ-018 IDLE->RUN on cfg handshake: latch cfg_len into down-counter, latch both sign flags, clear accumulator and product-valid.
REQ-019 RUN: each pair handshake decrements counter; handshake with counter==0 -> DRAIN.
REQ-020 in_valid gaps in RUN stall the job without loss; no timeout.
REQ-021 Operand extension: each operand extended to DW+1 bits with MSB if its latched flag is 1, else 0; signed (DW+1)x(DW+1) product, 2*DW+1 bits, sign-extended to ACCW.
REQ-022 Stage 1: product registered with p_vld on the edge ending the pair handshake cycle.
REQ-023 Stage 2: accumulator += registered product on the edge ending any cycle with p_vld=1; wrap modulo 2^ACCW (cannot occur at defaults).
REQ-024 DRAIN lasts exactly one cycle -> DONE; out_valid rises two cycles after the final pair handshake cycle.
REQ-025 DONE: out_acc holds the final sum, stable while out_ready=0; on output handshake -> IDLE.
REQ-026 out_acc is the accumulator register directly; its value outside DONE is don't-care to consumers.
REQ-027 cfg_valid outside IDLE and in_valid outside RUN are ignored; no state change.
REQ-028 Sign flags are fixed for the whole job; changes on cfg_* inputs mid-job have no effect.
REQ-029 A new job is accepted no earlier than the cycle after the output handshake (no IDLE bypass).

Reset
REQ-030 rst=1 at a rising edge: state=IDLE, counter=0, p_vld=0, product=0, accumulator=0, sign flags=0, regardless of current state.
REQ-031 Outputs during/after reset: cfg_ready=1, in_ready=0, out_valid=0, busy=0, out_acc=0.
REQ-032 A job aborted by reset produces no output and leaves no residue in the next job.

Structure
REQ-033 Shared package dot_pkg holds the FSM state enum and default DW/ACCW/LENW constants.
REQ-034 One sub-module mac_mul: combinational extension + signed multiply (REQ-021); pipeline registers, counter, accumulator and FSM stay in dot_seq.

Verification
REQ-035 cfg_len=0, both signed, A=0x80, W=0x80 -> out_acc=16384, out_valid two cycles after handshake.
REQ-036 cfg_len=3, both unsigned, 4x(0xFF,0xFF) -> out_acc=260100.
REQ-037 cfg_len=0, A signed, W unsigned, A=0xFF, W=0xFF -> out_acc=-255.
REQ-038 cfg_len=255, both signed, 256x(0x80,0x7F), random in_valid gaps, out_ready low 5 cycles -> out_acc=-4161536 held stable, cfg_ready=0 until handshake.
REQ-039 rst pulse after 3 of 8 pairs -> next cycle cfg_ready=1, out_valid=0; next job cfg_len=1, signed, (2,3),(4,5) -> out_acc=26.
REQ-040 cfg_valid asserted during RUN and in_valid during IDLE -> ignored; results of surrounding jobs unchanged.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared types and default widths for the dot-product sequencer.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DW_DEF   = 8;
  localparam int ACCW_DEF = 32;
  localparam int LENW_DEF = 8;

endpackage

// File: rtl/mac_mul.sv
// Combinational operand extension and signed multiply; the result is sign-extended to ACCW.
module mac_mul
  import dot_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   w,
  input  logic            asigned,
  input  logic            wsigned,
  output logic [ACCW-1:0] prod
);

  // Both operands are taken at full product width so the multiply needs no extra extension.
  logic signed [2*DW:0] ax;
  logic signed [2*DW:0] wx;
  logic signed [2*DW:0] p;

  assign ax   = {{(DW+1){asigned & a[DW-1]}}, a};
  assign wx   = {{(DW+1){wsigned & w[DW-1]}}, w};
  assign p    = ax * wx;
  assign prod = {{(ACCW-2*DW-1){p[2*DW]}}, p};

endmodule

// File: rtl/dot_seq.sv
// Sequenced dot product: one pair per in handshake, out_valid two cycles after the last pair.
// Inputs stall freely; the result is held in DONE until out_ready.
module dot_seq
  import dot_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [LENW-1:0] cfg_len,
  input  logic            cfg_asigned,
  input  logic            cfg_wsigned,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc,
  output logic            busy
);

  state_t            state;
  logic [LENW-1:0]   cnt;
  logic              asg;
  logic              wsg;
  logic              p_vld;
  logic [ACCW-1:0]   prod;
  logic [ACCW-1:0]   prod_q;
  logic [ACCW-1:0]   acc;

  mac_mul #(.DW(DW), .ACCW(ACCW)) u_mul (
    .a       (in_a),
    .w       (in_w),
    .asigned (asg),
    .wsigned (wsg),
    .prod    (prod)
  );

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_acc   = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      asg    <= 1'b0;
      wsg    <= 1'b0;
      p_vld  <= 1'b0;
      prod_q <= '0;
      acc    <= '0;
    end else begin
      p_vld <= 1'b0;
      if (p_vld) acc <= acc + prod_q;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            state <= RUN;
            cnt   <= cfg_len;
            asg   <= cfg_asigned;
            wsg   <= cfg_wsigned;
            acc   <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            prod_q <= prod;
            p_vld  <= 1'b1;
            if (cnt == '0) state <= DRAIN;
            else           cnt   <= cnt - LENW'(1);
          end
        end
        // The last product lands in the accumulator on the edge leaving DRAIN.
        DRAIN: state <= DONE;
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_seq.sv
// Directed bench for dot_seq with an arithmetic reference model and a per-cycle result checker.
module tb_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_len;
  logic        cfg_asigned;
  logic        cfg_wsigned;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_w;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_acc;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ta [0:255];
  logic [7:0]  tw [0:255];
  logic [31:0] exp_acc = '0;
  bit          exp_out = 1'b0;

  always #5 clk = ~clk;

  dot_seq dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_len     (cfg_len),
    .cfg_asigned (cfg_asigned),
    .cfg_wsigned (cfg_wsigned),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_w        (in_w),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h) at %0t",
               name, $signed(act), act, $signed(req), req, $time);
    end
  endtask

  function automatic longint ext(input logic [7:0] x, input bit s);
    if (s) return longint'($signed(x));
    return longint'(x);
  endfunction

  // Reference: plain integer sum of products, truncated to the 32-bit result.
  function automatic logic [31:0] model(input int clen, input bit as, input bit ws);
    longint sum;
    sum = 0;
    for (int i = 0; i <= clen; i++) sum += ext(ta[i], as) * ext(tw[i], ws);
    return sum[31:0];
  endfunction

  // Whenever a result is presented it must be expected and match the model.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("vld_expected", {31'b0, exp_out}, 32'd1);
      if (exp_out) chk("acc_model", out_acc, exp_acc);
    end
  end

  // Starts and ends just after a rising edge. abort_at >= 0 returns after that many pairs.
  task automatic run_job(input int clen, input bit as, input bit ws, input int gmax,
                         input int stall, input bit inject, input int abort_at, input int lit);
    int t;
    int g;
    logic [31:0] m;
    m = model(clen, as, ws);
    if (abort_at < 0) chk("model_pin", m, lit);
    cfg_valid = 1'b1; cfg_len = clen[7:0]; cfg_asigned = as; cfg_wsigned = ws;
    @(negedge clk);
    t = 0;
    while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
    chk("cfg_hs", {31'b0, cfg_ready}, 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int i = 0; i <= clen; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        return;
      end
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_a = 8'hA5; in_w = 8'h5A;
        if (inject) begin
          cfg_valid = 1'b1; cfg_len = 8'd0; cfg_asigned = ~as; cfg_wsigned = ~ws;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_a = ta[i]; in_w = tw[i];
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; @(negedge clk); t++; end
      chk("in_hs", {31'b0, in_ready}, 32'd1);
      if (i == 0) chk("busy_run", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; cfg_valid = 1'b0; cfg_asigned = as; cfg_wsigned = ws;
    exp_acc = m; exp_out = 1'b1;
    @(negedge clk);
    chk("drain_no_vld", {31'b0, out_valid}, 32'd0);
    chk("drain_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("latency_vld", {31'b0, out_valid}, 32'd1);
    chk("acc_lit", out_acc, lit);
    repeat (stall) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_vld", {31'b0, out_valid}, 32'd1);
      chk("hold_cfg_rdy", {31'b0, cfg_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; exp_out = 1'b0;
    @(negedge clk);
    chk("out_hs_clear", {31'b0, out_valid}, 32'd0);
    chk("idle_cfg_rdy", {31'b0, cfg_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_asigned = 1'b0; cfg_wsigned = 1'b0;
    in_valid = 1'b0; in_a = '0; in_w = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_rdy", {31'b0, cfg_ready}, 32'd1);
    chk("rst_in_rdy",  {31'b0, in_ready},  32'd0);
    chk("rst_out_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",    {31'b0, busy},      32'd0);
    chk("rst_acc",     out_acc,            32'd0);
    @(posedge clk); #1;

    ta[0] = 8'h80; tw[0] = 8'h80;
    run_job(0, 1'b1, 1'b1, 0, 0, 1'b0, -1, 16384);

    for (int i = 0; i < 4; i++) begin ta[i] = 8'hFF; tw[i] = 8'hFF; end
    run_job(3, 1'b0, 1'b0, 0, 1, 1'b0, -1, 260100);

    ta[0] = 8'hFF; tw[0] = 8'hFF;
    run_job(0, 1'b1, 1'b0, 0, 0, 1'b0, -1, -255);

    // in_valid while idle must be ignored.
    in_valid = 1'b1; in_a = 8'h55; in_w = 8'h33;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_rdy", {31'b0, in_ready}, 32'd0);
      chk("idle_stays",  {31'b0, cfg_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // cfg_valid with flipped flags during RUN must be ignored: -15 - 14 + 256.
    ta[0] = 8'hFD; tw[0] = 8'h05;
    ta[1] = 8'h07; tw[1] = 8'hFE;
    ta[2] = 8'h10; tw[2] = 8'h10;
    run_job(2, 1'b1, 1'b1, 3, 0, 1'b1, -1, 227);

    for (int i = 0; i < 256; i++) begin ta[i] = 8'h80; tw[i] = 8'h7F; end
    run_job(255, 1'b1, 1'b1, 2, 5, 1'b1, -1, -4161536);

    // Abort a job with reset after 3 of 8 pairs.
    for (int i = 0; i < 8; i++) begin ta[i] = 8'h7F; tw[i] = 8'h7F; end
    run_job(7, 1'b1, 1'b1, 0, 0, 1'b0, 3, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cfg_rdy", {31'b0, cfg_ready}, 32'd1);
    chk("abort_out_vld", {31'b0, out_valid}, 32'd0);
    chk("abort_busy",    {31'b0, busy},      32'd0);
    chk("abort_acc",     out_acc,            32'd0);
    @(posedge clk); #1;

    ta[0] = 8'd2; tw[0] = 8'd3;
    ta[1] = 8'd4; tw[1] = 8'd5;
    run_job(1, 1'b1, 1'b1, 0, 0, 1'b0, -1, 26);

    ta[0] = 8'hFF; tw[0] = 8'hFF;
    run_job(0, 1'b1, 1'b0, 0, 0, 1'b0, -1, -255);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
